// File: rtl/id_ex_pipe_if.sv
// ID/EX stage bus: decode-side inputs, control requests,
// execute-side outputs and status.
interface id_ex_pipe_if #(
  parameter int XLEN    = 32,
  parameter int INST_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [INST_W-1:0]  inst_i;
  logic [XLEN-1:0]    inst_addr_i;
  logic [XLEN-1:0]    reg1_rdata_i;
  logic [XLEN-1:0]    reg2_rdata_i;
  logic               reg_we_i;
  logic [RADDR_W-1:0] reg_waddr_i;
  logic [XLEN-1:0]    op1_i;
  logic [XLEN-1:0]    op2_i;
  logic [XLEN-1:0]    op1_jump_i;
  logic [XLEN-1:0]    op2_jump_i;
  logic               hold_i;
  logic               flush_i;
  logic               out_ready_i;
  logic               out_valid_o;
  logic [INST_W-1:0]  inst_o;
  logic [XLEN-1:0]    inst_addr_o;
  logic [XLEN-1:0]    reg1_rdata_o;
  logic [XLEN-1:0]    reg2_rdata_o;
  logic               reg_we_o;
  logic [RADDR_W-1:0] reg_waddr_o;
  logic [XLEN-1:0]    op1_o;
  logic [XLEN-1:0]    op2_o;
  logic [XLEN-1:0]    op1_jump_o;
  logic [XLEN-1:0]    op2_jump_o;
  logic [1:0]         occupancy_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport master (
    output in_valid_i, inst_i, inst_addr_i,
    output reg1_rdata_i, reg2_rdata_i,
    output reg_we_i, reg_waddr_i,
    output op1_i, op2_i, op1_jump_i, op2_jump_i,
    output hold_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o,
    input  inst_o, inst_addr_o,
    input  reg1_rdata_o, reg2_rdata_o,
    input  reg_we_o, reg_waddr_o,
    input  op1_o, op2_o, op1_jump_o, op2_jump_o,
    input  occupancy_o, stall_cnt_o
  );

  modport slave (
    input  in_valid_i, inst_i, inst_addr_i,
    input  reg1_rdata_i, reg2_rdata_i,
    input  reg_we_i, reg_waddr_i,
    input  op1_i, op2_i, op1_jump_i, op2_jump_i,
    input  hold_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o,
    output inst_o, inst_addr_o,
    output reg1_rdata_o, reg2_rdata_o,
    output reg_we_o, reg_waddr_o,
    output op1_o, op2_o, op1_jump_o, op2_jump_o,
    output occupancy_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake,
// 2-entry skid buffer, stall counter and flush.
module id_ex_pipe #(
  parameter int XLEN    = 32,
  parameter int INST_W  = 32,
  parameter int RADDR_W = 5,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter int CNT_W   = 16
) (
  input  logic         clk_100MHz,
  input  logic         arst_n,
  id_ex_pipe_if.slave  bus
);

  typedef struct packed {
    logic [INST_W-1:0]  inst;
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    r1;
    logic [XLEN-1:0]    r2;
    logic               we;
    logic [RADDR_W-1:0] waddr;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [XLEN-1:0]    j1;
    logic [XLEN-1:0]    j2;
  } pl_t;

  localparam int PW = $bits(pl_t);
  localparam pl_t BUBBLE =
    pl_t'({NOP_INST, {(PW-INST_W){1'b0}}});
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pl_t              m_q;
  pl_t              s_q;
  logic             m_v;
  logic             s_v;
  logic [CNT_W-1:0] cnt_q;

  pl_t  in_pl;
  pl_t  out_pl;
  logic rdy;
  logic acc;
  logic take;
  logic do_flush;
  logic do_adv;
  logic do_skid;

  assign in_pl = {
    bus.inst_i, bus.inst_addr_i,
    bus.reg1_rdata_i, bus.reg2_rdata_i,
    bus.reg_we_i, bus.reg_waddr_i,
    bus.op1_i, bus.op2_i,
    bus.op1_jump_i, bus.op2_jump_i
  };

  assign rdy  = bus.out_ready_i & ~bus.hold_i;
  assign acc  = bus.in_valid_i & ~s_v;
  assign take = m_v & rdy;

  assign do_flush = bus.flush_i;
  assign do_adv   = ~bus.flush_i & (~m_v | take);
  assign do_skid  = ~bus.flush_i & m_v & ~take & acc;

  // Main/skid entry update: flush, advance, or absorb into skid
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      m_q <= BUBBLE;
      s_q <= BUBBLE;
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else begin
      unique case (1'b1)
        do_flush: begin
          m_q <= BUBBLE;
          m_v <= 1'b0;
          s_v <= 1'b0;
        end
        do_adv: begin
          if (s_v) begin
            m_q <= s_q;
            m_v <= 1'b1;
            s_v <= 1'b0;
          end else if (acc) begin
            m_q <= in_pl;
            m_v <= 1'b1;
          end else begin
            m_q <= BUBBLE;
            m_v <= 1'b0;
          end
        end
        do_skid: begin
          s_q <= in_pl;
          s_v <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of cycles a valid output is stalled
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (m_v && !rdy && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_pl = m_v ? m_q : BUBBLE;

  assign {
    bus.inst_o, bus.inst_addr_o,
    bus.reg1_rdata_o, bus.reg2_rdata_o,
    bus.reg_we_o, bus.reg_waddr_o,
    bus.op1_o, bus.op2_o,
    bus.op1_jump_o, bus.op2_jump_o
  } = out_pl;

  assign bus.out_valid_o = m_v;
  assign bus.in_ready_o  = ~s_v;
  assign bus.occupancy_o = {1'b0, m_v} + {1'b0, s_v};
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_id_ex_pipe;

  localparam int PW = 262;
  localparam int CMAX = 15;
  localparam logic [PW-1:0] BUB =
    {32'h00000013, 230'd0};

  logic clk = 1'b0;
  logic arst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] mq[$];
  int mcnt = 0;

  id_ex_pipe_if #(
    .XLEN(32), .INST_W(32), .RADDR_W(5), .CNT_W(4)
  ) bus ();

  id_ex_pipe #(
    .XLEN(32), .INST_W(32), .RADDR_W(5),
    .NOP_INST(32'h00000013), .CNT_W(4)
  ) dut (
    .clk_100MHz(clk),
    .arst_n(arst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] in_vec();
    return {bus.inst_i, bus.inst_addr_i,
            bus.reg1_rdata_i, bus.reg2_rdata_i,
            bus.reg_we_i, bus.reg_waddr_i,
            bus.op1_i, bus.op2_i,
            bus.op1_jump_i, bus.op2_jump_i};
  endfunction

  function automatic logic [PW-1:0] out_vec();
    return {bus.inst_o, bus.inst_addr_o,
            bus.reg1_rdata_o, bus.reg2_rdata_o,
            bus.reg_we_o, bus.reg_waddr_o,
            bus.op1_o, bus.op2_o,
            bus.op1_jump_o, bus.op2_jump_o};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_pl(logic [PW-1:0] act,
                        logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL payload: got %h expected %h t=%0t",
               act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two accepted instructions
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      bit r;
      bit a;
      r = bus.out_ready_i && !bus.hold_i;
      a = bus.in_valid_i && mq.size() < 2;
      if (mq.size() > 0 && !r && mcnt < CMAX) mcnt++;
      if (bus.flush_i) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && r) void'(mq.pop_front());
        if (a) mq.push_back(in_vec());
      end
    end
  end

  // Cycle-by-cycle comparison against the reference
  always @(negedge clk) begin
    logic [PW-1:0] e;
    e = (mq.size() > 0) ? mq[0] : BUB;
    chk("out_valid", 32'(bus.out_valid_o),
        32'(mq.size() > 0));
    chk("in_ready", 32'(bus.in_ready_o),
        32'(mq.size() < 2));
    chk("occupancy", 32'(bus.occupancy_o),
        32'(mq.size()));
    chk("stall_cnt", 32'(bus.stall_cnt_o),
        32'(mcnt));
    chk_pl(out_vec(), e);
  end

  task automatic drive(bit v, bit h, bit f, bit r,
                       logic [31:0] addr);
    @(negedge clk);
    bus.in_valid_i   = v;
    bus.hold_i       = h;
    bus.flush_i      = f;
    bus.out_ready_i  = r;
    bus.inst_i       = $urandom;
    bus.inst_addr_i  = addr;
    bus.reg1_rdata_i = $urandom;
    bus.reg2_rdata_i = $urandom;
    bus.reg_we_i     = 1'($urandom);
    bus.reg_waddr_i  = 5'($urandom);
    bus.op1_i        = $urandom;
    bus.op2_i        = $urandom;
    bus.op1_jump_i   = $urandom;
    bus.op2_jump_i   = $urandom;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_valid"}, 32'(bus.out_valid_o), 0);
    chk({nm, "_inst"}, bus.inst_o, 32'h13);
    chk({nm, "_we"}, 32'(bus.reg_we_o), 0);
    chk({nm, "_addr"}, bus.inst_addr_o, 0);
    chk({nm, "_ready"}, 32'(bus.in_ready_o), 1);
    chk({nm, "_occ"}, 32'(bus.occupancy_o), 0);
    chk({nm, "_cnt"}, 32'(bus.stall_cnt_o), 0);
  endtask

  initial begin
    logic [31:0] exp_a[7];
    logic [31:0] a3[7];
    bus.in_valid_i   = 0;
    bus.hold_i       = 0;
    bus.flush_i      = 0;
    bus.out_ready_i  = 1;
    bus.inst_i       = 0;
    bus.inst_addr_i  = 0;
    bus.reg1_rdata_i = 0;
    bus.reg2_rdata_i = 0;
    bus.reg_we_i     = 0;
    bus.reg_waddr_i  = 0;
    bus.op1_i        = 0;
    bus.op2_i        = 0;
    bus.op1_jump_i   = 0;
    bus.op2_jump_i   = 0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;

    // 1: idle after reset
    @(negedge clk);
    #1;
    chk_reset_vals("t1");

    // 2: stream four with one-cycle latency
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 1, 32'(4 * k));
      post();
      chk("t2_addr", bus.inst_addr_o, 32'(4 * k));
      chk("t2_valid", 32'(bus.out_valid_o), 1);
      chk("t2_cnt", 32'(bus.stall_cnt_o), 0);
    end
    drive(0, 0, 0, 1, 0);
    post();
    chk("t2_drain", 32'(bus.out_valid_o), 0);

    // 3: hold for 3 cycles, upstream re-presents
    a3 = '{32'h100, 32'h104, 32'h108, 32'h108,
           32'h108, 32'h108, 32'h10c};
    exp_a = '{32'h100, 32'h100, 32'h100, 32'h100,
              32'h104, 32'h108, 32'h10c};
    for (int k = 0; k < 7; k++) begin
      drive(1, (k >= 1 && k <= 3), 0, 1, a3[k]);
      post();
      chk("t3_addr", bus.inst_addr_o, exp_a[k]);
      if (k == 1)
        chk("t3_occ_peak", 32'(bus.occupancy_o), 2);
      if (k == 1)
        chk("t3_ready_low", 32'(bus.in_ready_o), 0);
      if (k == 4)
        chk("t3_ready_back", 32'(bus.in_ready_o), 1);
    end
    chk("t3_cnt", 32'(bus.stall_cnt_o), 3);
    drive(0, 0, 0, 1, 0);
    post();

    // 4: flush while full, with input and hold
    drive(1, 1, 0, 1, 32'h200);
    post();
    drive(1, 1, 0, 1, 32'h204);
    post();
    chk("t4_occ", 32'(bus.occupancy_o), 2);
    drive(1, 1, 1, 1, 32'h208);
    post();
    chk("t4_valid", 32'(bus.out_valid_o), 0);
    chk("t4_inst", bus.inst_o, 32'h13);
    chk("t4_we", 32'(bus.reg_we_o), 0);
    chk("t4_occ0", 32'(bus.occupancy_o), 0);
    chk("t4_ready", 32'(bus.in_ready_o), 1);
    drive(0, 0, 0, 1, 0);
    post();
    chk("t4_gone", 32'(bus.out_valid_o), 0);

    // 6: long hold saturates the counter
    drive(1, 1, 0, 1, 32'h300);
    repeat (20) drive(0, 1, 0, 1, 0);
    post();
    chk("t6_sat", 32'(bus.stall_cnt_o), 15);
    chk("t6_addr", bus.inst_addr_o, 32'h300);
    drive(0, 1, 0, 1, 0);
    post();
    chk("t6_stay", 32'(bus.stall_cnt_o), 15);

    // 5: async reset while full and held
    drive(1, 1, 0, 1, 32'h304);
    post();
    chk("t5_occ", 32'(bus.occupancy_o), 2);
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk_reset_vals("t5");
    @(negedge clk);
    #2 arst_n = 1'b1;
    drive(1, 0, 0, 1, 32'h400);
    post();
    chk("t5_resume", bus.inst_addr_o, 32'h400);
    chk("t5_rvalid", 32'(bus.out_valid_o), 1);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        @(negedge clk);
        #2 arst_n = 1'b0;
        @(negedge clk);
        #2 arst_n = 1'b1;
      end
      drive($urandom_range(9) < 7,
            $urandom_range(9) < 2,
            $urandom_range(19) == 0,
            $urandom_range(9) < 8,
            32'(n * 4));
    end
    drive(0, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

- Parametrised ID/EX pipeline register with valid/ready flow control, a 2-entry skid buffer, stall and flush.
- Sits between decode and execute.
- Replaces a plain clocked register so that hold and flush no longer lose or duplicate an instruction.
- An empty slot always presents a NOP bubble (`addi x0,x0,0`) with `reg_we_o = 0`.

## Interface
Parameters:
- XLEN, 32: width of instruction address, register data and operand fields.
- INST_W, 32: instruction width.
- RADDR_W, 5: register-file address width.
- NOP_INST, 32'h00000013: bubble instruction value.
- CNT_W, 16: stall counter width.

Ports:
- clk_100MHz  in  1  clock, rising edge.
- arst_n  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  decode presents a valid instruction.
- in_ready_o  out  1  stage can accept this cycle.
- inst_i, inst_addr_i  in  INST_W, XLEN  instruction and its address.
- reg1_rdata_i, reg2_rdata_i  in  XLEN  register-file read data.
- reg_we_i  in  1  register write enable.
- reg_waddr_i  in  RADDR_W  register write address.
- op1_i, op2_i, op1_jump_i, op2_jump_i  in  XLEN  ALU and jump operands.
- hold_i  in  1  stall request from control.
- flush_i  in  1  flush request from control (branch taken, exception).
- out_ready_i  in  1  execute can accept.
- out_valid_o  out  1  outputs hold a valid instruction.
- inst_o … op2_jump_o  out  same widths as the inputs  registered payload.
- occupancy_o  out  2  number of entries held: 0, 1 or 2.
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles.

## Operation
Storage:
- Main entry M drives all outputs; out_valid_o = M.valid.
- Skid entry S has its own valid bit.

Derived signals:
- in_ready_o = ~S.valid (registered, never depends on in_valid_i in the same cycle).
- Effective downstream ready: rdy = out_ready_i & ~hold_i.
- acc = in_valid_i & in_ready_o.
- take = M.valid & rdy.

Per-cycle update, highest priority first:
1. flush_i = 1:
   - M.valid = 0, S.valid = 0, M payload = bubble.
   - A simultaneous acc is dropped.
2. M empty or take:
   - If S.valid: M <= S and S.valid = 0; acc cannot occur because in_ready_o = 0.
   - Else if acc: M <= input.
   - Else: M becomes bubble with valid 0.
3. M full and not taken:
   - If acc: S <= input, S.valid = 1.
   - Otherwise M and S are unchanged.

Payload rules:
- Bubble payload: inst_o = NOP_INST, reg_we_o = 0, every other field 0.
- Whenever M.valid = 0, the payload is forced to the bubble.

Counters:
- occupancy_o = M.valid + S.valid.
- stall_cnt_o increments when out_valid_o & ~rdy.
  - Saturates at 2^CNT_W−1.
  - Not cleared by flush; cleared only by reset.

Ordering:
- Instructions leave in acceptance order.
- No instruction is duplicated or lost except by flush.

## Timing
- Reset (async assert, sync-released use): out_valid_o = 0, payload = bubble (inst_o = 0x00000013, reg_we_o = 0, rest 0), in_ready_o = 1, occupancy_o = 0, stall_cnt_o = 0.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (one cycle), provided M was empty or taken.
- Throughput: one instruction per cycle while rdy = 1.
- hold_i / out_ready_i low:
  - First accept is absorbed by S.
  - in_ready_o falls in the following cycle.
  - Outputs are frozen bit-exact.
- Release after stall: S drains into M on the first edge with rdy = 1; in_ready_o returns high the cycle after.
- Flush: outputs show the bubble from the next edge; in_ready_o = 1 and occupancy_o = 0 the next cycle.
- hold_i and flush_i together: flush wins.
- Reset mid-transfer: all state returns to reset values immediately; the in-flight payload is discarded.

## Test plan
1. Release reset with no stimulus → out_valid_o = 0, inst_o = 0x00000013, reg_we_o = 0, in_ready_o = 1, occupancy_o = 0.
2. Stream 4 instructions (inst_addr 0x0, 0x4, 0x8, 0xC) with out_ready_i = 1 → each appears exactly one cycle after acceptance, out_valid_o continuously high, stall_cnt_o = 0.
3. Streaming with hold_i high for 3 cycles → S captures one instruction, in_ready_o drops, no loss or reorder, stall_cnt_o = 3, occupancy_o peaks at 2.
4. occupancy_o = 2, then flush_i together with in_valid_i → next cycle out_valid_o = 0, inst_o = NOP, reg_we_o = 0, occupancy_o = 0; the flushed input never appears.
5. Assert arst_n low while occupancy_o = 2 and hold_i = 1 → all outputs immediately at reset values; normal streaming resumes after release.
6. CNT_W = 4, hold_i high for 20 cycles with out_valid_o = 1 → stall_cnt_o saturates at 15 and remains 15.
